vrf_scoreboard: RTL and testbench

- Parametrised vector register file for the RSA pipeline CPU.
- Generalises the fixed 10-entry, 6x8-bit file to configurable lane count, lane width and depth.
- Adds per-lane write masking, reset clearing and an out-of-range address guard.
- Adds an integrated busy-bit scoreboard that decode uses to detect RAW/WAW hazards against in-flight writebacks.
- Placement: decode reads operands and issues destinations; writeback drives the write port.

---
 rtl/vrf_scoreboard.sv | 109 ++++++++++
 tb/tb_vrf_scoreboard.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/vrf_scoreboard.sv
// Parametrised vector register file with per-lane write mask and a busy-bit scoreboard for decode hazards.
// Optional write-first forwarding of data and busy state is enabled by defining VRF_BYPASS_EN.
module vrf_scoreboard #(
    parameter int LANES  = 6,
    parameter int LANE_W = 8,
    parameter int DEPTH  = 10,
    parameter int AW     = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    we,
    input  logic [AW-1:0]           waddr,
    input  logic [LANES*LANE_W-1:0] wdata,
    input  logic [LANES-1:0]        wmask,
    input  logic [AW-1:0]           ra1,
    input  logic [AW-1:0]           ra2,
    output logic [LANES*LANE_W-1:0] rd1,
    output logic [LANES*LANE_W-1:0] rd2,
    input  logic                    issue,
    input  logic [AW-1:0]           issue_dst,
    output logic                    busy1,
    output logic                    busy2,
    output logic                    busy_dst,
    output logic [AW-1:0]           wb_idx,
    output logic                    wb_valid
);

    localparam int DW = LANES * LANE_W;

    logic [DW-1:0]    rf [DEPTH];
    logic [DEPTH-1:0] busy;
    logic             wr_ok;
    logic             wr_acc;

    function automatic logic in_rng(input logic [AW-1:0] a);
        return int'(a) < DEPTH;
    endfunction

    // wr_ok moves lane data; wr_acc additionally needs a live lane to count as a writeback
    assign wr_ok  = we && in_rng(waddr);
    assign wr_acc = wr_ok && (wmask != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int d = 0; d < DEPTH; d++) rf[d] <= '0;
        end else if (wr_ok) begin
            for (int l = 0; l < LANES; l++) begin
                if (wmask[l]) rf[waddr][l*LANE_W +: LANE_W] <= wdata[l*LANE_W +: LANE_W];
            end
        end
    end

    // Issue has priority over a same-cycle clear: the new producer is still outstanding
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= '0;
        end else begin
            for (int d = 0; d < DEPTH; d++) begin
                if (issue && in_rng(issue_dst) && issue_dst == AW'(d)) busy[d] <= 1'b1;
                else if (wr_acc && waddr == AW'(d))                    busy[d] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_valid <= 1'b0;
            wb_idx   <= '0;
        end else begin
            wb_valid <= wr_acc;
            if (wr_acc) wb_idx <= waddr;
        end
    end

    function automatic logic [DW-1:0] read_port(input logic [AW-1:0] a);
        logic [DW-1:0] v;
        v = '0;
        if (in_rng(a)) begin
            v = rf[a];
`ifdef VRF_BYPASS_EN
            if (!rst && wr_ok && a == waddr) begin
                for (int l = 0; l < LANES; l++) begin
                    if (wmask[l]) v[l*LANE_W +: LANE_W] = wdata[l*LANE_W +: LANE_W];
                end
            end
`endif
        end
        return v;
    endfunction

    function automatic logic busy_of(input logic [AW-1:0] a);
        logic b;
        b = 1'b0;
        if (in_rng(a)) begin
            b = busy[a];
`ifdef VRF_BYPASS_EN
            if (!rst && wr_acc && a == waddr && !(issue && issue_dst == waddr)) b = 1'b0;
`endif
        end
        return b;
    endfunction

    assign rd1      = read_port(ra1);
    assign rd2      = read_port(ra2);
    assign busy1    = busy_of(ra1);
    assign busy2    = busy_of(ra2);
    assign busy_dst = busy_of(issue_dst);

endmodule

// File: tb/tb_vrf_scoreboard.sv
// Scoreboard bench for vrf_scoreboard: a reference model pushes expected values, DUT outputs pop and compare.
module tb_vrf_scoreboard;
    localparam int LANES = 6, LANE_W = 8, DEPTH = 10, AW = 4, DW = 48;

    logic          clk = 1'b0;
    logic          rst, we, issue;
    logic [AW-1:0] waddr, ra1, ra2, issue_dst;
    logic [DW-1:0] wdata;
    logic [5:0]    wmask;
    logic [DW-1:0] rd1, rd2;
    logic          busy1, busy2, busy_dst, wb_valid;
    logic [AW-1:0] wb_idx;

    always #5 clk = ~clk;

    vrf_scoreboard #(.LANES(LANES), .LANE_W(LANE_W), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata), .wmask(wmask),
        .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2), .issue(issue), .issue_dst(issue_dst),
        .busy1(busy1), .busy2(busy2), .busy_dst(busy_dst), .wb_idx(wb_idx), .wb_valid(wb_valid)
    );

    logic [DW-1:0] m_rf [16];
    logic [15:0]   m_busy;
    logic          m_wbv;
    logic [AW-1:0] m_wbi;

    typedef struct { string tag; logic [63:0] exp; } exp_t;
    exp_t sbq[$];
    int n_tests = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input logic [63:0] e);
        exp_t x;
        x.tag = tag;
        x.exp = e;
        sbq.push_back(x);
    endtask

    task automatic pop_chk(input logic [63:0] obs);
        exp_t x;
        if (sbq.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL sbq_empty: got %h expected <queued value>", obs);
        end else begin
            x = sbq.pop_front();
            chk(x.tag, obs, x.exp);
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < 16; i++) m_rf[i] = '0;
        m_busy = '0;
        m_wbv  = 1'b0;
        m_wbi  = '0;
    endtask

    function automatic logic [DW-1:0] mrd(input logic [AW-1:0] a);
        logic [DW-1:0] v;
        if (a >= DEPTH) return '0;
        v = m_rf[a];
`ifdef VRF_BYPASS_EN
        if (!rst && we && waddr == a)
            for (int l = 0; l < LANES; l++)
                if (wmask[l]) v[l*8 +: 8] = wdata[l*8 +: 8];
`endif
        return v;
    endfunction

    function automatic logic mbusy(input logic [AW-1:0] a);
        logic b;
        if (a >= DEPTH) return 1'b0;
        b = m_busy[a];
`ifdef VRF_BYPASS_EN
        if (!rst && we && wmask != 0 && waddr == a && !(issue && issue_dst == a)) b = 1'b0;
`endif
        return b;
    endfunction

    task automatic check_reads(input string tag);
        push({tag, "_rd1"}, 64'(mrd(ra1)));
        push({tag, "_rd2"}, 64'(mrd(ra2)));
        push({tag, "_busy1"}, 64'(mbusy(ra1)));
        push({tag, "_busy2"}, 64'(mbusy(ra2)));
        push({tag, "_busy_dst"}, 64'(mbusy(issue_dst)));
        #1;
        pop_chk(64'(rd1));
        pop_chk(64'(rd2));
        pop_chk(64'(busy1));
        pop_chk(64'(busy2));
        pop_chk(64'(busy_dst));
    endtask

    task automatic check_wb(input string tag);
        push({tag, "_wb_valid"}, 64'(m_wbv));
        push({tag, "_wb_idx"}, 64'(m_wbi));
        pop_chk(64'(wb_valid));
        pop_chk(64'(wb_idx));
    endtask

    // Model next state from pre-edge inputs, then advance the clock and compare the echo
    task automatic tick(input string tag);
        logic [DW-1:0] nrow;
        logic [15:0]   nbusy;
        logic          acc, nwbv;
        logic [AW-1:0] nwbi;
        acc   = we && waddr < DEPTH && wmask != 0;
        nrow  = (waddr < DEPTH) ? m_rf[waddr] : '0;
        nbusy = m_busy;
        if (we && waddr < DEPTH)
            for (int l = 0; l < LANES; l++)
                if (wmask[l]) nrow[l*8 +: 8] = wdata[l*8 +: 8];
        if (acc) nbusy[waddr] = 1'b0;
        if (issue && issue_dst < DEPTH) nbusy[issue_dst] = 1'b1;
        nwbv = acc;
        nwbi = acc ? waddr : m_wbi;
        @(posedge clk);
        if (rst) m_reset();
        else begin
            if (we && waddr < DEPTH) m_rf[waddr] = nrow;
            m_busy = nbusy;
            m_wbv  = nwbv;
            m_wbi  = nwbi;
        end
        #1;
        check_wb(tag);
    endtask

    initial begin
        rst = 1'b1; we = 1'b0; issue = 1'b0; waddr = '0; ra1 = '0; ra2 = '0;
        issue_dst = '0; wdata = '0; wmask = '0;
        m_reset();
        #2;
        check_reads("rst_hold");
        check_wb("rst_hold");
        @(posedge clk); #1;
        rst = 1'b0;

        for (int a = 0; a < DEPTH; a++) begin
            ra1 = AW'(a);
            ra2 = AW'(DEPTH - 1 - a);
            check_reads("t1_zero");
        end
        ra1 = 4'd12;
        check_reads("t1_oor");

        we = 1'b1; waddr = 4'd3; wdata = 48'h0605_0403_0201; wmask = 6'b111111;
        tick("t2_wr");
        we = 1'b0; ra1 = 4'd3;
        check_reads("t2_rd");
        chk("t2_lit", 64'(rd1), 64'h0605_0403_0201);

        we = 1'b1; wdata = 48'hFFFF_FFFF_FFFF; wmask = 6'b000101;
        tick("t3_mask");
        we = 1'b0;
        check_reads("t3_rd");
        chk("t3_lit", 64'(rd1), 64'h0605_04FF_02FF);
        we = 1'b1; wdata = '0; wmask = '0;
        tick("t3_nomask");
        we = 1'b0;
        check_reads("t3_rd2");

        issue = 1'b1; issue_dst = 4'd5;
        tick("t4_issue");
        issue = 1'b0; ra2 = 4'd5;
        check_reads("t4_busy");
        we = 1'b1; waddr = 4'd5; wdata = 48'h1234_5678_9ABC; wmask = 6'b111111;
        check_reads("t4_wrcyc");
        tick("t4_clr");
        we = 1'b0;
        check_reads("t4_cleared");
        issue = 1'b1;
        tick("t4_reissue");
        we = 1'b1;
        check_reads("t4_both_cyc");
        tick("t4_both");
        we = 1'b0; issue = 1'b0;
        check_reads("t4_stay");

        we = 1'b1; waddr = 4'd7; wdata = 48'h1111_1111_1111; wmask = 6'b111111;
        tick("t5_pre");
        ra1 = 4'd7; wdata = 48'hAAAA_AAAA_AAAA;
        check_reads("t5_wrcyc");
        tick("t5_wr");
        we = 1'b0;
        check_reads("t5_after");
        we = 1'b1; wdata = 48'h5555_5555_5555; wmask = 6'b001111;
        check_reads("t5_partial");
        tick("t5_pwr");
        we = 1'b0;
        check_reads("t5_pafter");

        issue = 1'b1; issue_dst = 4'd2;
        tick("t6_issue");
        issue = 1'b0; we = 1'b1; waddr = 4'd4; wdata = 48'hDEAD_BEEF_0001;
        tick("t6_wr");
        ra1 = 4'd3; ra2 = 4'd5; issue_dst = 4'd2;
        #2;
        rst = 1'b1;
        m_reset();
        check_reads("t6_async");
        check_wb("t6_async");
        tick("t6_hold");
        rst = 1'b0;
        we = 1'b1; waddr = 4'd10; wdata = 48'hFFFF_FFFF_FFFF; wmask = 6'b111111;
        tick("t6_oor_wr");
        we = 1'b0;
        for (int a = 0; a < DEPTH; a++) begin
            ra1 = AW'(a);
            ra2 = 4'd10;
            check_reads("t6_after");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got no finish expected finish before 20000");
        $fatal(1, "timeout");
    end
endmodule
